// File: rtl/snake_pkg.sv
// Shared codes, bus field offsets and direction helpers for the snake game-state engine.
package snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  typedef enum logic [1:0] {
    STAGE_IDLE = 2'd0,
    STAGE_PLAY = 2'd2,
    STAGE_OVER = 2'd3
  } stage_t;

  localparam int BOARD_W = 40;
  localparam int BUS_W   = 488;

  // Bit offsets of each field inside snake_data, as decoded by the renderer
  localparam int FLD_TRAIL1 = 0;
  localparam int FLD_TRAIL2 = 100;
  localparam int FLD_HEAD1  = 200;
  localparam int FLD_HEAD2  = 232;
  localparam int FLD_LEN1   = 264;
  localparam int FLD_LEN2   = 296;
  localparam int FLD_STAGE  = 328;
  localparam int FLD_HEARTS = 456;

  localparam logic [6:0] HEARTS_FULL = 7'd100;
  localparam logic [5:0] INIT_LEN    = 6'd3;

  function automatic logic signed [11:0] dir_offset(input logic [1:0] d);
    case (d)
      DIR_UP:    dir_offset = -12'sd40;
      DIR_RIGHT: dir_offset = 12'sd1;
      DIR_DOWN:  dir_offset = 12'sd40;
      DIR_LEFT:  dir_offset = -12'sd1;
      default:   dir_offset = 12'sd0;
    endcase
  endfunction

  function automatic logic [1:0] dir_opposite(input logic [1:0] d);
    return d ^ 2'd2;
  endfunction

endpackage

// File: rtl/snake_mover.sv
// One snake: button latch, heading, row/col/bus position, 50-entry trail and length.
module snake_mover
  import snake_pkg::*;
#(
  parameter int         INIT_ROW = 10,
  parameter int         INIT_COL = 10,
  parameter logic [1:0] INIT_DIR = DIR_RIGHT,
  parameter int         MAX_LEN  = 50
) (
  input  logic         clk,
  input  logic         init,
  input  logic         latch_en,
  input  logic         move,
  input  logic         grow,
  input  logic         btn_up,
  input  logic         btn_right,
  input  logic         btn_down,
  input  logic         btn_left,
  output logic         wall_hit,
  output logic [10:0]  next_pos,
  output logic [10:0]  pos,
  output logic [99:0]  trail,
  output logic [5:0]   len
);

  localparam logic [10:0] INIT_POS   = 11'(INIT_ROW * BOARD_W + INIT_COL);
  localparam logic [1:0]  INIT_TRAIL = INIT_DIR ^ 2'd2;

  logic [5:0]  row_r, col_r, next_row_s, next_col_s;
  logic [10:0] pos_r;
  logic [1:0]  heading_r, pending_r, mv_dir_s, opp_s;
  logic [99:0] trail_r;
  logic [5:0]  len_r;

  // Highest-priority pressed button wins, skipping the one that would reverse the snake
  always_comb begin
    opp_s = dir_opposite(heading_r);
    if (btn_up && (opp_s != DIR_UP)) begin
      mv_dir_s = DIR_UP;
    end else if (btn_right && (opp_s != DIR_RIGHT)) begin
      mv_dir_s = DIR_RIGHT;
    end else if (btn_down && (opp_s != DIR_DOWN)) begin
      mv_dir_s = DIR_DOWN;
    end else if (btn_left && (opp_s != DIR_LEFT)) begin
      mv_dir_s = DIR_LEFT;
    end else begin
      mv_dir_s = pending_r;
    end
  end

  // Wall test on the pre-move cell and the candidate next cell
  always_comb begin
    wall_hit   = 1'b0;
    next_row_s = row_r;
    next_col_s = col_r;
    case (mv_dir_s)
      DIR_UP: begin
        wall_hit   = (row_r == 6'd0);
        next_row_s = row_r - 6'd1;
      end
      DIR_DOWN: begin
        wall_hit   = (row_r == 6'd39);
        next_row_s = row_r + 6'd1;
      end
      DIR_RIGHT: begin
        wall_hit   = (col_r == 6'd39);
        next_col_s = col_r + 6'd1;
      end
      DIR_LEFT: begin
        wall_hit   = (col_r == 6'd0);
        next_col_s = col_r - 6'd1;
      end
      default: wall_hit = 1'b0;
    endcase
    next_pos = pos_r + 11'(dir_offset(mv_dir_s));
  end

  // Snake state: reinit, move one cell, or just latch the pending direction
  always_ff @(posedge clk) begin
    if (init) begin
      row_r     <= 6'(INIT_ROW);
      col_r     <= 6'(INIT_COL);
      pos_r     <= INIT_POS;
      heading_r <= INIT_DIR;
      pending_r <= INIT_DIR;
      trail_r   <= {50{INIT_TRAIL}};
      len_r     <= INIT_LEN;
    end else if (move) begin
      row_r     <= next_row_s;
      col_r     <= next_col_s;
      pos_r     <= next_pos;
      heading_r <= mv_dir_s;
      pending_r <= mv_dir_s;
      trail_r   <= {trail_r[97:0], dir_opposite(mv_dir_s)};
      if (grow && (len_r < 6'(MAX_LEN))) begin
        len_r <= len_r + 6'd1;
      end else begin
        len_r <= len_r;
      end
    end else if (latch_en) begin
      pending_r <= mv_dir_s;
    end else begin
      pending_r <= pending_r;
    end
  end

  assign pos   = pos_r;
  assign trail = trail_r;
  assign len   = len_r;

endmodule

// File: rtl/snake_state_writer.sv
// Game-state engine: move tick, stage FSM, hearts timer, apple and the packed renderer bus.
module snake_state_writer
  import snake_pkg::*;
#(
  parameter int TICK_DIV   = 25_000_000,
  parameter int HEART_STEP = 1,
  parameter int APPLE_POS  = 425,
  parameter int MAX_LEN    = 50
) (
  input  logic             iVGA_CLK,
  input  logic             iRST,
  input  logic             iSTART,
  input  logic             up,
  input  logic             down,
  input  logic             left,
  input  logic             right,
  input  logic             up2,
  input  logic             down2,
  input  logic             left2,
  input  logic             right2,
  output logic [BUS_W-1:0] snake_data,
  output logic             oTICK
);

  stage_t      stage_r, stage_nxt_s;
  logic [31:0] cnt_r, cnt_nxt_s;
  logic [6:0]  hearts_r, hearts_nxt_s;
  logic        tick_r, tick_nxt_s;
  logic        playing_s, init_s, wrap_s, wall_s, move_s, eat1_s, eat2_s;
  logic        wall1_s, wall2_s;
  logic [10:0] next1_s, next2_s, pos1_s, pos2_s;
  logic [99:0] trail1_s, trail2_s;
  logic [5:0]  len1_s, len2_s;

  assign playing_s = (stage_r == STAGE_PLAY);
  assign init_s    = iRST || (!playing_s && iSTART);
  assign wrap_s    = playing_s && (cnt_r == 32'(TICK_DIV - 1));
  assign wall_s    = wall1_s || wall2_s;
  assign move_s    = wrap_s && !wall_s;
  assign eat1_s    = (next1_s == 11'(APPLE_POS));
  assign eat2_s    = (next2_s == 11'(APPLE_POS));

  snake_mover #(
    .INIT_ROW(10), .INIT_COL(10), .INIT_DIR(DIR_RIGHT), .MAX_LEN(MAX_LEN)
  ) u_snake1 (
    .clk(iVGA_CLK), .init(init_s), .latch_en(playing_s), .move(move_s), .grow(eat1_s),
    .btn_up(up), .btn_right(right), .btn_down(down), .btn_left(left),
    .wall_hit(wall1_s), .next_pos(next1_s), .pos(pos1_s), .trail(trail1_s), .len(len1_s)
  );

  snake_mover #(
    .INIT_ROW(30), .INIT_COL(29), .INIT_DIR(DIR_LEFT), .MAX_LEN(MAX_LEN)
  ) u_snake2 (
    .clk(iVGA_CLK), .init(init_s), .latch_en(playing_s), .move(move_s), .grow(eat2_s),
    .btn_up(up2), .btn_right(right2), .btn_down(down2), .btn_left(left2),
    .wall_hit(wall2_s), .next_pos(next2_s), .pos(pos2_s), .trail(trail2_s), .len(len2_s)
  );

  // Stage, tick counter and hearts next-state; a wall hit freezes the frame without a tick
  always_comb begin
    stage_nxt_s  = stage_r;
    cnt_nxt_s    = cnt_r;
    hearts_nxt_s = hearts_r;
    tick_nxt_s   = 1'b0;
    case (stage_r)
      STAGE_IDLE, STAGE_OVER: begin
        if (iSTART) begin
          stage_nxt_s  = STAGE_PLAY;
          cnt_nxt_s    = 32'd0;
          hearts_nxt_s = HEARTS_FULL;
        end else begin
          stage_nxt_s = stage_r;
        end
      end
      STAGE_PLAY: begin
        if (wrap_s) begin
          cnt_nxt_s = 32'd0;
        end else begin
          cnt_nxt_s = cnt_r + 32'd1;
        end
        if (wrap_s && wall_s) begin
          stage_nxt_s = STAGE_OVER;
        end else if (move_s) begin
          tick_nxt_s = 1'b1;
          if (eat1_s || eat2_s) begin
            hearts_nxt_s = HEARTS_FULL;
          end else if (hearts_r <= 7'(HEART_STEP)) begin
            hearts_nxt_s = 7'd0;
            stage_nxt_s  = STAGE_OVER;
          end else begin
            hearts_nxt_s = hearts_r - 7'(HEART_STEP);
          end
        end else begin
          stage_nxt_s = stage_r;
        end
      end
      default: stage_nxt_s = STAGE_IDLE;
    endcase
  end

  // Top-level state registers
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      stage_r  <= STAGE_IDLE;
      cnt_r    <= 32'd0;
      hearts_r <= HEARTS_FULL;
      tick_r   <= 1'b0;
    end else begin
      stage_r  <= stage_nxt_s;
      cnt_r    <= cnt_nxt_s;
      hearts_r <= hearts_nxt_s;
      tick_r   <= tick_nxt_s;
    end
  end

  // Bus packing straight from registers; unlisted fields (head indices, spare) stay zero
  always_comb begin
    snake_data                       = '0;
    snake_data[FLD_TRAIL1 +: 100]    = trail1_s;
    snake_data[FLD_TRAIL2 +: 100]    = trail2_s;
    snake_data[FLD_HEAD1  +: 32]     = {21'd0, pos1_s};
    snake_data[FLD_HEAD2  +: 32]     = {21'd0, pos2_s};
    snake_data[FLD_LEN1   +: 32]     = {26'd0, len1_s};
    snake_data[FLD_LEN2   +: 32]     = {26'd0, len2_s};
    snake_data[FLD_STAGE  +: 32]     = {30'd0, stage_r};
    snake_data[FLD_HEARTS +: 32]     = {25'd0, hearts_r};
  end

  assign oTICK = tick_r;

endmodule

// File: tb/tb_snake_state_writer.sv
// Scoreboard bench: expected tick snapshots are queued by the stimulus, popped on oTICK.
module tb_snake_state_writer;

  logic clk = 1'b0;
  logic rst_a, start_a, up, down, left, right, up2, down2, left2, right2;
  logic rst_b, start_b;
  logic [487:0] data_a, data_b;
  logic otick_a, otick_b;

  always #5 clk = ~clk;

  snake_state_writer #(.TICK_DIV(4)) dut_a (
    .iVGA_CLK(clk), .iRST(rst_a), .iSTART(start_a),
    .up(up), .down(down), .left(left), .right(right),
    .up2(up2), .down2(down2), .left2(left2), .right2(right2),
    .snake_data(data_a), .oTICK(otick_a)
  );

  snake_state_writer #(.TICK_DIV(4), .HEART_STEP(50)) dut_b (
    .iVGA_CLK(clk), .iRST(rst_b), .iSTART(start_b),
    .up(1'b0), .down(1'b0), .left(1'b0), .right(1'b0),
    .up2(1'b0), .down2(1'b0), .left2(1'b0), .right2(1'b0),
    .snake_data(data_b), .oTICK(otick_b)
  );

  typedef struct {
    int h1; int h2; int l1; int hearts; int stage; int t1; int t2;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int ncmp = 0, nfail = 0, cnt_a = 0, cnt_b = 0;
  int eh1, eh2, el1, ehe, c0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fld(input logic [487:0] d, input int lsb);
    return d[lsb +: 32];
  endfunction

  task automatic check_snap(input string tag, input logic [487:0] d, input exp_t e);
    chk({tag, "_head1"},  fld(d, 200), e.h1);
    chk({tag, "_head2"},  fld(d, 232), e.h2);
    chk({tag, "_len1"},   fld(d, 264), e.l1);
    chk({tag, "_hearts"}, fld(d, 456), e.hearts);
    chk({tag, "_stage"},  fld(d, 328), e.stage);
    chk({tag, "_trail1"}, d[1:0], e.t1);
    chk({tag, "_trail2"}, d[101:100], e.t2);
  endtask

  task automatic check_init(input string tag, input logic [487:0] d, input int stage);
    logic [99:0] all_left, all_right;
    all_left  = {50{2'b11}};
    all_right = {50{2'b01}};
    chk({tag, "_head1"},  fld(d, 200), 410);
    chk({tag, "_head2"},  fld(d, 232), 1229);
    chk({tag, "_len1"},   fld(d, 264), 3);
    chk({tag, "_len2"},   fld(d, 296), 3);
    chk({tag, "_stage"},  fld(d, 328), stage);
    chk({tag, "_hearts"}, fld(d, 456), 100);
    chk({tag, "_trail1"}, d[99:0], all_left);
    chk({tag, "_trail2"}, d[199:100], all_right);
    chk({tag, "_zero"},   d[455:360], 0);
  endtask

  // Monitors: every oTICK pops one expected snapshot
  always @(negedge clk) begin
    if (otick_a) begin
      if (qa.size() == 0) begin
        ncmp++; nfail++;
        $display("FAIL tick_a_extra: actual 1 required 0");
      end else begin
        check_snap("tick_a", data_a, qa.pop_front());
      end
      cnt_a++;
    end
  end

  always @(negedge clk) begin
    if (otick_b) begin
      if (qb.size() == 0) begin
        ncmp++; nfail++;
        $display("FAIL tick_b_extra: actual 1 required 0");
      end else begin
        check_snap("tick_b", data_b, qb.pop_front());
      end
      cnt_b++;
    end
  end

  task automatic tick_expect(input bit b, input exp_t e);
    int start_cnt;
    bit seen;
    start_cnt = b ? cnt_b : cnt_a;
    seen = 1'b0;
    if (b) qb.push_back(e); else qa.push_back(e);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); #1;
      seen = ((b ? cnt_b : cnt_a) != start_cnt);
    end
    if (!seen) begin
      ncmp++; nfail++;
      $display("FAIL tick_timeout: actual 0 required 1 (dut %0d)", b);
      if (b) qb.delete(qb.size() - 1); else qa.delete(qa.size() - 1);
    end
  endtask

  task automatic move_a(input int off1, input int tr1, input int off2, input int tr2);
    exp_t e;
    eh1 += off1;
    eh2 += off2;
    if (eh1 == 425) begin
      el1 = el1 + 1;
      ehe = 100;
    end else begin
      ehe = ehe - 1;
    end
    e = '{eh1, eh2, el1, ehe, 2, tr1, tr2};
    tick_expect(1'b0, e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    {up, down, left, right, up2, down2, left2, right2} = 8'd0;
    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    repeat (2) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    check_init("reset", data_a, 0);
    chk("reset_otick", otick_a, 0);

    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("start_stage", fld(data_a, 328), 2);
    eh1 = 410; eh2 = 1229; el1 = 3; ehe = 100;

    move_a(1, 3, -1, 1);
    left = 1'b1;  move_a(1, 3, -1, 1);   left = 1'b0;
    down = 1'b1;  move_a(40, 0, -1, 1);  down = 1'b0;
    right = 1'b1; move_a(1, 3, -1, 1);   right = 1'b0;
    up = 1'b1;    move_a(-40, 2, -1, 1); up = 1'b0;
    right = 1'b1;
    for (int i = 0; i < 12; i++) move_a(1, 3, -1, 1);
    up2 = 1'b1;
    for (int i = 0; i < 14; i++) move_a(1, 3, -40, 2);

    c0 = cnt_a;
    repeat (10) @(negedge clk);
    chk("wall_no_tick", cnt_a, c0);
    chk("wall_stage", fld(data_a, 328), 3);
    chk("wall_head1", fld(data_a, 200), 439);
    chk("wall_head2", fld(data_a, 232), 652);
    right = 1'b0; up2 = 1'b0;

    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check_init("restart", data_a, 2);
    eh1 = 410; eh2 = 1229; el1 = 3; ehe = 100;
    move_a(1, 3, -1, 1);

    @(negedge clk);
    rst_a = 1'b1; start_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0; start_a = 1'b0;
    check_init("irst", data_a, 0);
    chk("irst_otick", otick_a, 0);
    c0 = cnt_a;
    repeat (8) @(negedge clk);
    chk("idle_no_tick", cnt_a, c0);

    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    tick_expect(1'b1, '{411, 1228, 3, 50, 2, 3, 1});
    tick_expect(1'b1, '{412, 1227, 3, 0, 3, 3, 1});
    c0 = cnt_b;
    repeat (10) @(negedge clk);
    chk("hearts_over_no_tick", cnt_b, c0);
    chk("hearts_over_stage", fld(data_b, 328), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
